// File: rtl/rr_arb_pkg.sv
// Shared types and helpers for the hold-capable round-robin arbiter.
// The two FSM states are IDLE (no owner) and GRANT (one requester owns the resource).
package rr_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    // Width of an index into v items, never below one bit.
    function automatic int clog2_min1(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

    // Binary position of the (single) set bit; 0 when nothing is set.
    function automatic int onehot_to_index(input logic [31:0] v);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if (v[i]) r = i;
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational rotating priority encoder: returns the first set request bit
// found scanning ptr, ptr+1, ... N-1, 0, ... ptr-1.
module rr_priority_pick
    import rr_arb_pkg::*;
#(
    parameter  int N   = 4,
    localparam int IDW = clog2_min1(N)
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic           any,
    output logic [IDW-1:0] idx
);

    logic [N-1:0] rot;
    int           off;
    int           sum;

    // Rotating a doubled copy right by ptr puts requester ptr at bit 0, so a
    // plain lowest-bit search gives the offset from ptr.
    always_comb begin
        rot = N'({req, req} >> ptr);
        off = 0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) off = i;
        end
        sum = int'(ptr) + off;
        if (sum >= N) sum = sum - N;
        idx = IDW'(sum);
        any = |req;
    end

endmodule

// File: rtl/rr_arbiter_hold.sv
// Round-robin arbiter with registered one-hot grant; an owner may keep the
// grant for up to MAX_HOLD cycles while others wait, indefinitely when alone.
module rr_arbiter_hold
    import rr_arb_pkg::*;
#(
    parameter  int N        = 4,
    parameter  int MAX_HOLD = 16,
    localparam int IDW      = clog2_min1(N),
    localparam int HW       = $clog2(MAX_HOLD + 1)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [N-1:0]   request,
    output logic [N-1:0]   grant,
    output logic           grant_valid,
    output logic [IDW-1:0] grant_id,
    output logic [HW-1:0]  hold_cnt,
    output logic           state
);

    localparam logic [HW-1:0]  HOLD_LAST = HW'(MAX_HOLD - 1);
    localparam logic [IDW-1:0] ID_LAST   = IDW'(N - 1);

    state_e         state_q, state_d;
    logic [N-1:0]   grant_q, grant_d;
    logic           valid_q;
    logic [IDW-1:0] id_q, id_d;
    logic [HW-1:0]  hold_q, hold_d;
    logic [IDW-1:0] ptr_q, ptr_d;

    logic           owner_req;
    logic [N-1:0]   others;
    logic [N-1:0]   pick_req;
    logic           pick_any;
    logic [IDW-1:0] pick_idx;
    logic [N-1:0]   win_oh;
    logic [IDW-1:0] ptr_after;
    logic           take;

    assign owner_req = |(request & grant_q);
    assign others    = request & ~grant_q;
    // In GRANT, ptr_q already equals owner+1, which is where the search for
    // the next owner starts.
    assign pick_req  = (state_q == IDLE) ? request : others;

    rr_priority_pick #(.N(N)) u_pick (
        .req (pick_req),
        .ptr (ptr_q),
        .any (pick_any),
        .idx (pick_idx)
    );

    assign win_oh    = {{(N-1){1'b0}}, 1'b1} << pick_idx;
    assign ptr_after = (pick_idx == ID_LAST) ? '0 : pick_idx + IDW'(1);

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        id_d    = id_q;
        hold_d  = hold_q;
        ptr_d   = ptr_q;
        take    = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_any) take = 1'b1;
            end
            GRANT: begin
                if (!owner_req) begin
                    if (pick_any) begin
                        take = 1'b1;
                    end else begin
                        state_d = IDLE;
                        grant_d = '0;
                        id_d    = '0;
                        hold_d  = '0;
                    end
                end else if (hold_q < HOLD_LAST) begin
                    hold_d = hold_q + HW'(1);
                end else if (pick_any) begin
                    take = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (take) begin
            state_d = GRANT;
            grant_d = win_oh;
            id_d    = pick_idx;
            hold_d  = '0;
            ptr_d   = ptr_after;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            valid_q <= 1'b0;
            id_q    <= '0;
            hold_q  <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            valid_q <= |grant_d;
            id_q    <= id_d;
            hold_q  <= hold_d;
            ptr_q   <= ptr_d;
        end
    end

    assign grant       = grant_q;
    assign grant_valid = valid_q;
    assign grant_id    = id_q;
    assign hold_cnt    = hold_q;
    assign state       = state_q;

endmodule

// File: tb/tb_rr_arbiter_hold.sv
// Directed bench for rr_arbiter_hold: N=4/MAX_HOLD=4, N=4/MAX_HOLD=1 and
// N=3/MAX_HOLD=4 instances sharing one clock and reset.
module tb_rr_arbiter_hold;

    logic       clk;
    logic       reset;

    logic [3:0] req_a, grant_a;
    logic       valid_a, state_a;
    logic [1:0] id_a;
    logic [2:0] hold_a;

    logic [3:0] req_b, grant_b;
    logic       valid_b, state_b;
    logic [1:0] id_b;
    logic [0:0] hold_b;

    logic [2:0] req_c, grant_c;
    logic       valid_c, state_c;
    logic [1:0] id_c;
    logic [2:0] hold_c;

    int checks;
    int errors;

    rr_arbiter_hold #(.N(4), .MAX_HOLD(4)) dut_a (
        .clk(clk), .reset(reset), .request(req_a), .grant(grant_a),
        .grant_valid(valid_a), .grant_id(id_a), .hold_cnt(hold_a), .state(state_a)
    );

    rr_arbiter_hold #(.N(4), .MAX_HOLD(1)) dut_b (
        .clk(clk), .reset(reset), .request(req_b), .grant(grant_b),
        .grant_valid(valid_b), .grant_id(id_b), .hold_cnt(hold_b), .state(state_b)
    );

    rr_arbiter_hold #(.N(3), .MAX_HOLD(4)) dut_c (
        .clk(clk), .reset(reset), .request(req_c), .grant(grant_c),
        .grant_valid(valid_c), .grant_id(id_c), .hold_cnt(hold_c), .state(state_c)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic expect_a(input string tag, input logic [3:0] g, input logic [1:0] id,
                            input logic [2:0] h);
        chk({tag, ".grant"}, 32'(grant_a), 32'(g));
        chk({tag, ".valid"}, 32'(valid_a), 32'(|g));
        chk({tag, ".id"},    32'(id_a),    32'(id));
        chk({tag, ".hold"},  32'(hold_a),  32'(h));
        chk({tag, ".state"}, 32'(state_a), 32'(|g));
    endtask

    initial begin
        int idx;
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        req_a  = '0;
        req_b  = '0;
        req_c  = '0;

        repeat (3) step();
        expect_a("reset", 4'b0000, 2'd0, 3'd0);
        reset = 1'b0;
        step();
        expect_a("idle0", 4'b0000, 2'd0, 3'd0);

        // all requesting: four cycles per tenure, hold_cnt 0..3
        req_a = 4'b1111;
        for (int t = 0; t <= 16; t++) begin
            step();
            idx = (t / 4) % 4;
            expect_a($sformatf("rot%0d", t), 4'(1 << idx), 2'(idx), 3'(t % 4));
        end

        // lone requester keeps the grant, hold_cnt saturates at 3
        req_a = 4'b0100;
        for (int t = 0; t < 10; t++) begin
            step();
            expect_a($sformatf("lone%0d", t), 4'b0100, 2'd2, 3'((t > 3) ? 3 : t));
        end

        req_a = 4'b0000;
        step();
        expect_a("drop", 4'b0000, 2'd0, 3'd0);

        // ptr=3 wraps to requester 0
        req_a = 4'b0001;
        step();
        expect_a("own0", 4'b0001, 2'd0, 3'd0);
        step();
        expect_a("own0h", 4'b0001, 2'd0, 3'd1);
        req_a = 4'b1010;
        step();
        expect_a("handoff", 4'b0010, 2'd1, 3'd0);
        req_a = 4'b0000;
        step();
        expect_a("release", 4'b0000, 2'd0, 3'd0);

        // last winner 1 -> ptr=2, scan 2,3 then wrap to 0
        req_a = 4'b0011;
        step();
        expect_a("wrap", 4'b0001, 2'd0, 3'd0);

        req_a = 4'b0100;
        step();
        expect_a("pre_rst", 4'b0100, 2'd2, 3'd0);
        reset = 1'b1;
        req_a = 4'b1111;
        step();
        expect_a("mid_rst", 4'b0000, 2'd0, 3'd0);
        reset = 1'b0;
        step();
        expect_a("post_rst", 4'b0001, 2'd0, 3'd0);

        // MAX_HOLD=1 and N=3 instances, fresh from reset
        reset = 1'b1;
        req_a = '0;
        step();
        reset = 1'b0;
        req_b = 4'b1111;
        req_c = 3'b111;
        for (int t = 0; t <= 12; t++) begin
            step();
            idx = t % 4;
            chk($sformatf("b%0d.grant", t), 32'(grant_b), 32'(1 << idx));
            chk($sformatf("b%0d.id", t),    32'(id_b),    32'(idx));
            chk($sformatf("b%0d.hold", t),  32'(hold_b),  32'(0));
            chk($sformatf("b%0d.valid", t), 32'(valid_b), 32'(1));
            idx = (t / 4) % 3;
            chk($sformatf("c%0d.grant", t), 32'(grant_c), 32'(1 << idx));
            chk($sformatf("c%0d.id", t),    32'(id_c),    32'(idx));
            chk($sformatf("c%0d.hold", t),  32'(hold_c),  32'(t % 4));
            chk($sformatf("c%0d.valid", t), 32'(valid_c), 32'(1));
        end

        req_b = 4'b0100;
        req_c = 3'b000;
        step();
        chk("b_lone.grant", 32'(grant_b), 32'(4'b0100));
        chk("c_idle.grant", 32'(grant_c), 32'(0));
        chk("c_idle.valid", 32'(valid_c), 32'(0));
        chk("c_idle.state", 32'(state_c), 32'(0));
        step();
        chk("b_keep.grant", 32'(grant_b), 32'(4'b0100));
        chk("b_keep.id",    32'(id_b),    32'(2));
        chk("b_keep.hold",  32'(hold_b),  32'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
